// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry FIFO that buffers legal ALU results with precomputed
// zero/negative flags, reports dropped unsupported op codes and counts downstream stalls.
module alu_result_stage #(
    parameter int DATA_WIDTH   = 36,
    parameter int ALU_OP_WIDTH = 3,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_ALU_Result,
    input  logic [ALU_OP_WIDTH-1:0] i_ALUControlS,
    input  logic [TAG_WIDTH-1:0]    i_dest,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic [TAG_WIDTH-1:0]    o_dest,
    output logic                    o_zero,
    output logic                    o_neg,
    output logic                    o_illegal,
    input  logic                    i_clr_stats,
    output logic [15:0]             o_stall_cnt
);

    // Supported ALU control encodings (shared with the ALU decoder).
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(3'b000);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3'b001);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(3'b010);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(3'b110);

    function automatic logic is_legal_op(input logic [ALU_OP_WIDTH-1:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [DATA_WIDTH-1:0] mem_result_r [2];
    logic [TAG_WIDTH-1:0]  mem_dest_r   [2];
    logic [1:0]            mem_zero_r;
    logic [1:0]            mem_neg_r;

    logic [1:0]            count_r;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic                  valid_r;
    logic                  ready_r;
    logic                  illegal_r;
    logic [15:0]           stall_cnt_r;
    logic [DATA_WIDTH-1:0] head_result_r;
    logic [TAG_WIDTH-1:0]  head_dest_r;
    logic                  head_zero_r;
    logic                  head_neg_r;

    logic                  present_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  stall_s;
    logic                  zero_in_s;
    logic                  neg_in_s;
    logic [1:0]            count_next_s;
    logic                  wr_ptr_next_s;
    logic                  rd_ptr_next_s;
    logic [DATA_WIDTH-1:0] head_result_next_s;
    logic [TAG_WIDTH-1:0]  head_dest_next_s;
    logic                  head_zero_next_s;
    logic                  head_neg_next_s;
    logic [15:0]           stall_cnt_next_s;

    // Handshake decode and FIFO occupancy/pointer update.
    always_comb begin
        present_s     = i_valid && ready_r;
        push_s        = present_s && is_legal_op(i_ALUControlS);
        pop_s         = valid_r && i_ready;
        stall_s       = valid_r && !i_ready;
        zero_in_s     = (i_ALU_Result == {DATA_WIDTH{1'b0}});
        neg_in_s      = i_ALU_Result[DATA_WIDTH-1];
        wr_ptr_next_s = wr_ptr_r ^ push_s;
        rd_ptr_next_s = rd_ptr_r ^ pop_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Next head entry; the incoming entry bypasses storage when it lands in the head slot.
    always_comb begin
        head_result_next_s = {DATA_WIDTH{1'b0}};
        head_dest_next_s   = {TAG_WIDTH{1'b0}};
        head_zero_next_s   = 1'b0;
        head_neg_next_s    = 1'b0;
        if (count_next_s == 2'd0) begin
            head_result_next_s = {DATA_WIDTH{1'b0}};
            head_dest_next_s   = {TAG_WIDTH{1'b0}};
            head_zero_next_s   = 1'b0;
            head_neg_next_s    = 1'b0;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_result_next_s = i_ALU_Result;
            head_dest_next_s   = i_dest;
            head_zero_next_s   = zero_in_s;
            head_neg_next_s    = neg_in_s;
        end else begin
            head_result_next_s = mem_result_r[rd_ptr_next_s];
            head_dest_next_s   = mem_dest_r[rd_ptr_next_s];
            head_zero_next_s   = mem_zero_r[rd_ptr_next_s];
            head_neg_next_s    = mem_neg_r[rd_ptr_next_s];
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cnt_next_s = stall_cnt_r;
        if (i_clr_stats) begin
            stall_cnt_next_s = 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_next_s = stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_next_s = stall_cnt_r;
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_result_r[0] <= {DATA_WIDTH{1'b0}};
            mem_result_r[1] <= {DATA_WIDTH{1'b0}};
            mem_dest_r[0]   <= {TAG_WIDTH{1'b0}};
            mem_dest_r[1]   <= {TAG_WIDTH{1'b0}};
            mem_zero_r      <= 2'b00;
            mem_neg_r       <= 2'b00;
            count_r         <= 2'd0;
            wr_ptr_r        <= 1'b0;
            rd_ptr_r        <= 1'b0;
            valid_r         <= 1'b0;
            ready_r         <= 1'b0;
            illegal_r       <= 1'b0;
            stall_cnt_r     <= 16'h0000;
            head_result_r   <= {DATA_WIDTH{1'b0}};
            head_dest_r     <= {TAG_WIDTH{1'b0}};
            head_zero_r     <= 1'b0;
            head_neg_r      <= 1'b0;
        end else begin
            if (push_s) begin
                mem_result_r[wr_ptr_r] <= i_ALU_Result;
                mem_dest_r[wr_ptr_r]   <= i_dest;
                mem_zero_r[wr_ptr_r]   <= zero_in_s;
                mem_neg_r[wr_ptr_r]    <= neg_in_s;
            end
            count_r       <= count_next_s;
            wr_ptr_r      <= wr_ptr_next_s;
            rd_ptr_r      <= rd_ptr_next_s;
            valid_r       <= (count_next_s != 2'd0);
            ready_r       <= (count_next_s != 2'd2);
            illegal_r     <= present_s && !is_legal_op(i_ALUControlS);
            stall_cnt_r   <= stall_cnt_next_s;
            head_result_r <= head_result_next_s;
            head_dest_r   <= head_dest_next_s;
            head_zero_r   <= head_zero_next_s;
            head_neg_r    <= head_neg_next_s;
        end
    end

    assign o_ready     = ready_r;
    assign o_valid     = valid_r;
    assign o_result    = head_result_r;
    assign o_dest      = head_dest_r;
    assign o_zero      = head_zero_r;
    assign o_neg       = head_neg_r;
    assign o_illegal   = illegal_r;
    assign o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized self-checking bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [35:0] i_ALU_Result = 36'h0;
    logic [2:0]  i_ALUControlS = 3'b000;
    logic [3:0]  i_dest = 4'h0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [35:0] o_result;
    logic [3:0]  o_dest;
    logic        o_zero;
    logic        o_neg;
    logic        o_illegal;
    logic        i_clr_stats = 1'b0;
    logic [15:0] o_stall_cnt;

    alu_result_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALU_Result(i_ALU_Result), .i_ALUControlS(i_ALUControlS), .i_dest(i_dest),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_dest(o_dest),
        .o_zero(o_zero), .o_neg(o_neg), .o_illegal(o_illegal),
        .i_clr_stats(i_clr_stats), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [35:0] res;
        logic [3:0]  dest;
    } ent_t;

    ent_t        q[$];
    bit          m_ready;
    bit          m_illegal;
    int unsigned m_stall;
    int          total = 0;
    int          bad = 0;

    wire [60:0] obs = {o_valid, o_ready, o_result, o_dest, o_zero, o_neg, o_illegal, o_stall_cnt};

    function automatic logic [60:0] exp_vec();
        logic [35:0] r;
        logic [3:0]  d;
        logic        v;
        v = (q.size() != 0);
        r = v ? q[0].res : 36'h0;
        d = v ? q[0].dest : 4'h0;
        return {v, m_ready, r, d, v && (r == 36'h0), v && r[35], m_illegal, 16'(m_stall)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ready = 1'b0;
        m_illegal = 1'b0;
        m_stall = 0;
    endtask

    // One clock of the reference behaviour, evaluated on the inputs about to be sampled.
    task automatic model_step();
        bit presented, legal, pop, stall;
        ent_t e;
        presented = i_valid && m_ready;
        legal = (i_ALUControlS inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
        pop = (q.size() > 0) && i_ready;
        stall = (q.size() > 0) && !i_ready;
        m_illegal = presented && !legal;
        if (i_clr_stats) m_stall = 0;
        else if (stall && m_stall < 65535) m_stall = m_stall + 1;
        if (pop) void'(q.pop_front());
        if (presented && legal) begin
            e.res = i_ALU_Result;
            e.dest = i_dest;
            q.push_back(e);
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [35:0] r,
                         input logic [3:0] d, input bit rdy);
        i_valid = v;
        i_ALUControlS = op;
        i_ALU_Result = r;
        i_dest = d;
        i_ready = rdy;
    endtask

    function automatic logic [2:0] rand_legal();
        logic [2:0] ops [4];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
        return ops[$urandom_range(0, 3)];
    endfunction

    function automatic logic [35:0] rand_data();
        logic [35:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 5) == 0) r = 36'h0;
        return r;
    endfunction

    task automatic test_reset();
        model_reset();
        #3;
        total++;
        if (obs !== 61'h0) begin
            bad++;
            $display("FAIL reset_hold act=%h exp=%h", obs, 61'h0);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        total++;
        if (o_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready act=%b exp=0", o_ready);
        end
        tick();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_first_edge act=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_basic();
        drive(1'b1, OP_ADD, 36'h5, 4'd3, 1'b1);
        tick();
        total++;
        if (obs !== exp_vec() || o_result !== 36'h5 || o_dest !== 4'd3 || o_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_add act=%h exp=%h", obs, exp_vec());
        end
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        tick();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL basic_drain act=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_stall();
        drive(1'b1, OP_SUB, 36'h0, 4'd7, 1'b0);
        tick();
        drive(1'b1, OP_OR, 36'h8_0000_0000, 4'd9, 1'b0);
        tick();
        total++;
        if (obs !== exp_vec() || o_ready !== 1'b0 || o_zero !== 1'b1) begin
            bad++;
            $display("FAIL stall_full act=%h exp=%h", obs, exp_vec());
        end
        drive(1'b1, OP_ADD, 36'h1234, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d act=%h exp=%h", i, obs, exp_vec());
            end
        end
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stall_drain cyc=%0d act=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_ops [4];
        bad_ops[0] = 3'b011; bad_ops[1] = 3'b100; bad_ops[2] = 3'b101; bad_ops[3] = 3'b111;
        drive(1'b1, OP_AND, 36'hF0F0, 4'd2, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bad_ops[i], rand_data(), 4'(i), 1'b0);
            tick();
            total++;
            if (obs !== exp_vec() || o_illegal !== 1'b1) begin
                bad++;
                $display("FAIL illegal_pulse op=%b act=%h exp=%h", bad_ops[i], obs, exp_vec());
            end
            drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b0);
            tick();
            total++;
            if (obs !== exp_vec() || o_illegal !== 1'b0) begin
                bad++;
                $display("FAIL illegal_clear op=%b act=%h exp=%h", bad_ops[i], obs, exp_vec());
            end
        end
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_ADD, rand_data(), 4'($urandom()), 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_legal(), rand_data(), 4'($urandom()), 1'b1);
            tick();
            total++;
            if (obs !== exp_vec() || q.size() != 1) begin
                bad++;
                $display("FAIL b2b cyc=%0d act=%h exp=%h", i, obs, exp_vec());
            end
        end
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        tick();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL b2b_drain act=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? 3'($urandom()) : rand_legal(),
                  rand_data(), 4'($urandom()), $urandom_range(0, 2) != 0);
            i_clr_stats = ($urandom_range(0, 30) == 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d act=%h exp=%h", i, obs, exp_vec());
            end
        end
        i_clr_stats = 1'b0;
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_saturate();
        drive(1'b1, OP_ADD, 36'h77, 4'd4, 1'b0);
        tick();
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        total++;
        if (obs !== exp_vec() || o_stall_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_value act=%h exp=%h", obs, exp_vec());
        end
        i_clr_stats = 1'b1;
        #1;
        total++;
        if (o_stall_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_clr_same act=%h exp=ffff", o_stall_cnt);
        end
        tick();
        i_clr_stats = 1'b0;
        total++;
        if (obs !== exp_vec() || o_stall_cnt !== 16'h0) begin
            bad++;
            $display("FAIL sat_clr_next act=%h exp=%h", obs, exp_vec());
        end
        tick();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL sat_restart act=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_OR, rand_data(), 4'd5, 1'b0);
        tick();
        tick();
        total++;
        if (obs !== exp_vec() || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_full act=%h exp=%h", obs, exp_vec());
        end
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs !== 61'h0) begin
            bad++;
            $display("FAIL rstmid_async act=%h exp=%h", obs, 61'h0);
        end
        drive(1'b0, OP_ADD, 36'h0, 4'd0, 1'b1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        total++;
        if (obs !== 61'h0) begin
            bad++;
            $display("FAIL rstmid_release act=%h exp=%h", obs, 61'h0);
        end
        tick();
        total++;
        if (obs !== exp_vec() || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ready act=%h exp=%h", obs, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
